// File: rtl/fractal_pkg.sv
// Shared definitions for the fractal result path: the collector FSM state encoding
// and the solver-memory address / solver-id widths.
package fractal_pkg;

  localparam int ADDR_W = 19;
  localparam int SID_W  = 6;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DONE,
    READ,
    FETCH,
    OUT,
    DONE
  } state_t;

endpackage

// File: rtl/result_collector_color_map.sv
// Palette mapping: escaped counts get their low byte bit-shuffled for visual contrast,
// and non-escaped (all-ones) counts become black.
module color_map #(
  parameter int ITER_W = 8
) (
  input  logic [ITER_W-1:0] i_iter,
  output logic [7:0]        o_pix
);

  logic [7:0] w_low;

  generate
    if (ITER_W > 8) begin : g_trunc
      assign w_low = i_iter[7:0];
    end else begin : g_ext
      assign w_low = 8'(i_iter);
    end
  endgenerate

  assign o_pix = (&i_iter) ? 8'h00 : {w_low[2:0], w_low[5:3], w_low[7:6]};

endmodule

// File: rtl/result_collector.sv
// Reads solver result memories pixel by pixel in row-major order and streams them out
// over a valid/ready handshake. Define COLOR_MAP_EN to route counts through color_map.
module result_collector
  import fractal_pkg::*;
#(
  parameter int NUM_SOLVERS = 1,
  parameter int WIDTH       = 99,
  parameter int HEIGHT      = 66,
  parameter int ITER_W      = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              solvers_done,
  output logic [SID_W-1:0]  rd_solver_id,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [ITER_W-1:0] rd_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [7:0]        pix_data,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST_P   = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [SID_W-1:0]  LAST_SID = SID_W'(NUM_SOLVERS - 1);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_p;
  logic [ADDR_W-1:0]   r_addr;
  logic [SID_W-1:0]    r_sid;
  logic [ITER_W-1:0]   r_iter;
  logic                w_hs;
  logic [7:0]          w_pix;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    w_next     = r_state;
    pix_valid  = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = WAIT_DONE;
      end
      WAIT_DONE: if (solvers_done) w_next = READ;
      READ:      w_next = FETCH;
      FETCH:     w_next = OUT;
      OUT: begin
        pix_valid = 1'b1;
        if (pix_ready) w_next = (r_p == LAST_P) ? DONE : READ;
      end
      DONE: begin
        frame_done = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_hs = pix_valid && pix_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_p     <= '0;
      r_addr  <= '0;
      r_sid   <= '0;
      r_iter  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH) r_iter <= rd_data;
      if (r_state == DONE) begin
        r_p    <= '0;
        r_addr <= '0;
        r_sid  <= '0;
        r_iter <= '0;
      end else if (w_hs && (r_p != LAST_P)) begin
        // Solver id cycles fastest; the per-solver word address advances on each wrap.
        r_p <= r_p + ADDR_W'(1);
        if (r_sid == LAST_SID) begin
          r_sid  <= '0;
          r_addr <= r_addr + ADDR_W'(1);
        end else begin
          r_sid <= r_sid + SID_W'(1);
        end
      end
    end
  end

`ifdef COLOR_MAP_EN
  color_map #(
    .ITER_W (ITER_W)
  ) u_color_map (
    .i_iter (r_iter),
    .o_pix  (w_pix)
  );
`else
  generate
    if (ITER_W > 8) begin : g_trunc
      assign w_pix = r_iter[7:0];
    end else begin : g_ext
      assign w_pix = 8'(r_iter);
    end
  endgenerate
`endif

  assign rd_solver_id = r_sid;
  assign rd_addr      = r_addr;
  assign pix_addr     = r_p;
  assign pix_data     = w_pix;

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have parameter NUM_SOLVERS, default 1: number of solver instances whose result memories are read.
REQ-002 SHALL have parameter WIDTH, default 99: frame width in pixels.
REQ-003 SHALL have parameter HEIGHT, default 66: frame height in pixels.
REQ-004 SHALL have parameter ITER_W, default 8: iteration-count width; the all-ones value means "did not escape".
REQ-005 SHALL have port clock, input, 1: the single clock.
REQ-006 SHALL have port reset, input, 1: one clock; reset is synchronous and active-low.
REQ-007 SHALL have port start, input, 1: single-cycle pulse requesting a frame readout.
REQ-008 SHALL have port solvers_done, input, 1: level signal, high once all solvers have finished the frame.
REQ-009 SHALL have port rd_solver_id, output, 6: selects the solver result memory to read.
REQ-010 SHALL have port rd_addr, output, 19: word address within the selected solver memory.
REQ-011 SHALL have port rd_data, input, ITER_W: iteration count returned one cycle after the address.
REQ-012 SHALL have port pix_valid, output, 1: a pixel is offered downstream.
REQ-013 SHALL have port pix_ready, input, 1: downstream accepts the pixel.
REQ-014 SHALL have port pix_addr, output, 19: linear frame-buffer address, row-major.
REQ-015 SHALL have port pix_data, output, 8: pixel value.
REQ-016 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-017 SHALL have port frame_done, output, 1: one-cycle pulse after the last pixel handshake.

Function
REQ-018 SHALL implement the states IDLE, WAIT_DONE, READ, FETCH, OUT and DONE.
REQ-019 SHALL move IDLE->WAIT_DONE on start; a start pulse in any other state SHALL be ignored.
REQ-020 SHALL move WAIT_DONE->READ in the first cycle solvers_done is high.
REQ-021 SHALL drive rd_solver_id/rd_addr for pixel p in READ, with pixel p owned by solver p mod NUM_SOLVERS at address p div NUM_SOLVERS; both SHALL be derived from counters (solver id wraps NUM_SOLVERS-1->0 and then increments addr), never from a divider.
REQ-022 SHALL move READ->FETCH, register rd_data in FETCH, and then move FETCH->OUT.
REQ-023 SHALL hold pix_valid high in OUT, with pix_addr=p and pix_data stable, until pix_ready is high; a handshake is pix_valid&&pix_ready.
REQ-024 SHALL, on a handshake with p<WIDTH*HEIGHT-1, increment p and move to READ; on a handshake with p=WIDTH*HEIGHT-1, move to DONE.
REQ-025 SHALL, in DONE, pulse frame_done for exactly one cycle and then return to IDLE with all counters cleared.
REQ-026 SHALL allow pix_ready to be high before pix_valid without that counting as a handshake.
REQ-027 SHALL sustain a throughput of at most one pixel per 3 cycles under continuous pix_ready.

Reset
REQ-028 SHALL, when reset is low at a clock edge, enter IDLE and clear p, solver id and addr, regardless of the current state.
REQ-029 SHALL reset all outputs to 0: pix_valid, pix_addr, pix_data, rd_solver_id, rd_addr, busy and frame_done.
REQ-030 SHALL abandon an interrupted frame without a frame_done pulse; the next frame SHALL require a new start.

Configuration
REQ-031 SHALL, with COLOR_MAP_EN defined, set pix_data=8'h00 when the count is all ones, and otherwise pix_data={it[2:0],it[5:3],it[7:6]} over the low 8 bits of the zero-extended count.
REQ-032 SHALL, without COLOR_MAP_EN, set pix_data to the low 8 bits of the count, zero-extended when ITER_W<8.

Structure
REQ-033 SHALL keep the state encoding, the address width (19) and the solver-id width (6) in the shared package fractal_pkg.
REQ-034 SHALL place the palette mapping in the combinational sub-module color_map, instantiated only under COLOR_MAP_EN.

Verification
REQ-035 SHALL cover: defaults with pix_ready=1, start, then solvers_done after 50 cycles -> 6534 handshakes with pix_addr 0..6533 in order, then one frame_done pulse.
REQ-036 SHALL cover: NUM_SOLVERS=3 -> pixel 4 reads rd_solver_id=1, rd_addr=1; pixel 6533 reads rd_solver_id=2, rd_addr=2177.
REQ-037 SHALL cover: pix_ready held low 5 cycles in OUT at pixel 10 -> pix_valid=1, pix_addr=10 and pix_data unchanged for all 5 cycles, then exactly one handshake.
REQ-038 SHALL cover: COLOR_MAP_EN with rd_data=8'hFF -> pix_data=8'h00; with rd_data=8'h2D -> 8'hB4; without the macro, 8'h2D -> 8'h2D.
REQ-039 SHALL cover: reset low for 1 cycle at pixel 100 -> all outputs 0 next cycle, no frame_done, and a new start replays the frame from pix_addr 0.
REQ-040 SHALL cover: start pulsed while busy -> no effect on the sequence or the count.
